// File: rtl/decode_stage_p_pkg.sv
// Shared encodings for the decode stage: opcodes, PC-source selects, memory
// micro-ops, control-bundle layouts and the sequencer state type.
package decode_pkg;

  localparam int OPW   = 6;
  localparam int EX_W  = 13;
  localparam int MEM_W = 7;
  localparam int WB_W  = 6;

  localparam logic [OPW-1:0] OP_NOP  = 6'd0;
  localparam logic [OPW-1:0] OP_MOV  = 6'd1;
  localparam logic [OPW-1:0] OP_ADD  = 6'd2;
  localparam logic [OPW-1:0] OP_SUB  = 6'd3;
  localparam logic [OPW-1:0] OP_AND  = 6'd4;
  localparam logic [OPW-1:0] OP_OR   = 6'd5;
  localparam logic [OPW-1:0] OP_NOT  = 6'd6;
  localparam logic [OPW-1:0] OP_INC  = 6'd7;
  localparam logic [OPW-1:0] OP_DEC  = 6'd8;
  localparam logic [OPW-1:0] OP_LDM  = 6'd9;
  localparam logic [OPW-1:0] OP_LDD  = 6'd10;
  localparam logic [OPW-1:0] OP_STD  = 6'd11;
  localparam logic [OPW-1:0] OP_PUSH = 6'd12;
  localparam logic [OPW-1:0] OP_POP  = 6'd13;
  localparam logic [OPW-1:0] OP_JMP  = 6'd14;
  localparam logic [OPW-1:0] OP_JZ   = 6'd15;
  localparam logic [OPW-1:0] OP_JC   = 6'd16;
  localparam logic [OPW-1:0] OP_CALL = 6'd17;
  localparam logic [OPW-1:0] OP_RET  = 6'd18;
  localparam logic [OPW-1:0] OP_RTI  = 6'd19;
  localparam logic [OPW-1:0] OP_OUT  = 6'd20;
  localparam logic [OPW-1:0] OP_IN   = 6'd21;

  localparam logic [1:0] JS_SEQ = 2'd0;
  localparam logic [1:0] JS_MEM = 2'd1;
  localparam logic [1:0] JS_VEC = 2'd2;

  localparam logic [2:0] MEM_NONE   = 3'd0;
  localparam logic [2:0] MEM_LOAD   = 3'd1;
  localparam logic [2:0] MEM_STORE  = 3'd2;
  localparam logic [2:0] MEM_PUSH   = 3'd3;
  localparam logic [2:0] MEM_POP    = 3'd4;
  localparam logic [2:0] MEM_PUSHPC = 3'd5;
  localparam logic [2:0] MEM_POPF   = 3'd6;
  localparam logic [2:0] MEM_PUSHF  = 3'd7;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_PASS = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_NOT  = 4'd6;
  localparam logic [3:0] ALU_INC  = 4'd7;
  localparam logic [3:0] ALU_DEC  = 4'd8;

  localparam logic [1:0] BR_NONE   = 2'd0;
  localparam logic [1:0] BR_ALWAYS = 2'd1;
  localparam logic [1:0] BR_Z      = 2'd2;
  localparam logic [1:0] BR_C      = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_IMM  = 2'd2;
  localparam logic [1:0] WB_PORT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RET_POP  = 2'd1,
    ST_RTI_POP  = 2'd2,
    ST_INT_PUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       use_src;
    logic       use_dst;
    logic       set_flags;
    logic       branch;
    logic [1:0] br_cond;
    logic       call;
    logic       out_port;
  } ex_ctl_t;

  typedef struct packed {
    logic [2:0] mem_op;
    logic       mem_read;
    logic       mem_write;
    logic       sp_inc;
    logic       sp_dec;
  } mem_ctl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] wb_sel;
    logic       flag_restore;
    logic       sp_write;
  } wb_ctl_t;

  typedef struct packed {
    ex_ctl_t  ex;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } ctl_bundle_t;

  typedef struct packed {
    state_t     state;
    logic [2:0] cnt;
    logic       irq_pend;
  } seq_dbg_t;

  // Stack micro-op bundle; the MEM stage does the SP arithmetic and writes it back.
  function automatic ctl_bundle_t uop_bundle(input logic [2:0] op);
    ctl_bundle_t b;
    b = '0;
    b.mem.mem_op  = op;
    b.wb.sp_write = 1'b1;
    if (op == MEM_POP || op == MEM_POPF) begin
      b.mem.mem_read = 1'b1;
      b.mem.sp_inc   = 1'b1;
    end else begin
      b.mem.mem_write = 1'b1;
      b.mem.sp_dec    = 1'b1;
    end
    b.wb.flag_restore = (op == MEM_POPF);
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_p_ctrl_rom.sv
// Combinational opcode-to-control-bundle lookup. RET and RTI decode to an
// empty bundle because the sequencer supplies their micro-ops.
module ctrl_rom
  import decode_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctl_bundle_t    bundle
);

  always_comb begin
    bundle = '0;
    case (opcode)
      OP_MOV: begin
        bundle.ex.alu_op    = ALU_PASS;
        bundle.ex.use_src   = 1'b1;
        bundle.wb.reg_write = 1'b1;
        bundle.wb.wb_sel    = WB_ALU;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        bundle.ex.use_src   = 1'b1;
        bundle.ex.use_dst   = 1'b1;
        bundle.ex.set_flags = 1'b1;
        bundle.wb.reg_write = 1'b1;
        case (opcode)
          OP_ADD:  bundle.ex.alu_op = ALU_ADD;
          OP_SUB:  bundle.ex.alu_op = ALU_SUB;
          OP_AND:  bundle.ex.alu_op = ALU_AND;
          default: bundle.ex.alu_op = ALU_OR;
        endcase
      end
      OP_NOT, OP_INC, OP_DEC: begin
        bundle.ex.use_dst   = 1'b1;
        bundle.ex.set_flags = 1'b1;
        bundle.wb.reg_write = 1'b1;
        case (opcode)
          OP_NOT:  bundle.ex.alu_op = ALU_NOT;
          OP_INC:  bundle.ex.alu_op = ALU_INC;
          default: bundle.ex.alu_op = ALU_DEC;
        endcase
      end
      OP_LDM: begin
        bundle.ex.use_imm   = 1'b1;
        bundle.wb.reg_write = 1'b1;
        bundle.wb.wb_sel    = WB_IMM;
      end
      OP_LDD: begin
        bundle.ex.use_imm    = 1'b1;
        bundle.mem.mem_op    = MEM_LOAD;
        bundle.mem.mem_read  = 1'b1;
        bundle.wb.reg_write  = 1'b1;
        bundle.wb.mem_to_reg = 1'b1;
        bundle.wb.wb_sel     = WB_MEM;
      end
      OP_STD: begin
        bundle.ex.use_imm    = 1'b1;
        bundle.ex.use_src    = 1'b1;
        bundle.mem.mem_op    = MEM_STORE;
        bundle.mem.mem_write = 1'b1;
      end
      OP_PUSH: begin
        bundle.ex.use_src    = 1'b1;
        bundle.mem.mem_op    = MEM_PUSH;
        bundle.mem.mem_write = 1'b1;
        bundle.mem.sp_dec    = 1'b1;
        bundle.wb.sp_write   = 1'b1;
      end
      OP_POP: begin
        bundle.mem.mem_op    = MEM_POP;
        bundle.mem.mem_read  = 1'b1;
        bundle.mem.sp_inc    = 1'b1;
        bundle.wb.reg_write  = 1'b1;
        bundle.wb.mem_to_reg = 1'b1;
        bundle.wb.wb_sel     = WB_MEM;
        bundle.wb.sp_write   = 1'b1;
      end
      OP_JMP, OP_JZ, OP_JC: begin
        bundle.ex.use_dst = 1'b1;
        bundle.ex.branch  = 1'b1;
        case (opcode)
          OP_JMP:  bundle.ex.br_cond = BR_ALWAYS;
          OP_JZ:   bundle.ex.br_cond = BR_Z;
          default: bundle.ex.br_cond = BR_C;
        endcase
      end
      OP_CALL: begin
        bundle.ex.use_dst    = 1'b1;
        bundle.ex.branch     = 1'b1;
        bundle.ex.br_cond    = BR_ALWAYS;
        bundle.ex.call       = 1'b1;
        bundle.mem.mem_op    = MEM_PUSHPC;
        bundle.mem.mem_write = 1'b1;
        bundle.mem.sp_dec    = 1'b1;
        bundle.wb.sp_write   = 1'b1;
      end
      OP_OUT: begin
        bundle.ex.use_src  = 1'b1;
        bundle.ex.out_port = 1'b1;
      end
      OP_IN: begin
        bundle.wb.reg_write = 1'b1;
        bundle.wb.wb_sel    = WB_PORT;
      end
      default: bundle = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: register file with write bypass, stack pointer, control
// bundle generation and the RET/RTI/interrupt stack micro-op sequencer.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int W           = 16,
  parameter int NREG        = 8,
  parameter int SPW         = 32,
  parameter int STACK_START = 2**11-1,
  parameter int PC_WORDS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPW-1:0]          opcode,
  input  logic [$clog2(NREG)-1:0] src,
  input  logic [$clog2(NREG)-1:0] dst,
  input  logic                    irq,
  input  logic                    reg_we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [W-1:0]            wd,
  input  logic                    sp_we,
  input  logic [W-1:0]            sp_value,
  input  logic                    branch_flush,
  input  logic                    hazard_stall,
  output logic [W-1:0]            rsrc,
  output logic [W-1:0]            rdst,
  output logic [SPW-1:0]          sp,
  output logic [EX_W-1:0]         ex_ctl,
  output logic [MEM_W-1:0]        mem_ctl,
  output logic [WB_W-1:0]         wb_ctl,
  output logic                    fd_en,
  output logic                    pc_en,
  output logic [1:0]              jump_sel,
  output logic                    seq_busy,
  output logic                    pop_ok,
  output seq_dbg_t                dbg
);

  // Last step index: RET_POP runs pops 0..PC_WORDS-1 then its jump;
  // INT_PUSH runs PUSHF, PC_WORDS pushes, then its jump.
  localparam logic [2:0] RET_LAST = 3'(PC_WORDS);
  localparam logic [2:0] INT_LAST = 3'(PC_WORDS + 1);

  logic [W-1:0]   regs [NREG];
  logic [SPW-1:0] sp_q;
  state_t         state, state_nx;
  logic [2:0]     cnt, cnt_nx;
  logic           irq_pend, irq_pend_nx;
  ctl_bundle_t    rom_bundle, uop, bundle;
  logic           squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[wa] <= wd;
    end
  end

  assign rsrc = (reg_we && wa == src) ? wd : regs[src];
  assign rdst = (reg_we && wa == dst) ? wd : regs[dst];

  always_ff @(posedge clk) begin
    if (rst) sp_q <= SPW'(STACK_START);
    else if (sp_we) sp_q <= SPW'($signed(sp_value));
  end

  assign sp = sp_q;

  ctrl_rom u_rom (
    .opcode (opcode),
    .bundle (rom_bundle)
  );

  assign squash = branch_flush | hazard_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      irq_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      irq_pend <= irq_pend_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    irq_pend_nx = irq_pend | irq;
    uop         = '0;
    fd_en       = 1'b1;
    pc_en       = 1'b1;
    jump_sel    = JS_SEQ;
    seq_busy    = 1'b0;
    case (state)
      ST_IDLE: begin
        // RET/RTI take precedence over a pending interrupt, which stays pending.
        if (!squash) begin
          if (opcode == OP_RET) begin
            state_nx = ST_RET_POP;
            cnt_nx   = '0;
          end else if (opcode == OP_RTI) begin
            state_nx = ST_RTI_POP;
            cnt_nx   = '0;
          end else if (irq_pend) begin
            state_nx    = ST_INT_PUSH;
            cnt_nx      = '0;
            irq_pend_nx = 1'b0;
          end
        end
      end
      ST_RTI_POP: begin
        seq_busy = 1'b1;
        fd_en    = 1'b0;
        pc_en    = 1'b0;
        uop      = uop_bundle(MEM_POPF);
        state_nx = ST_RET_POP;
        cnt_nx   = '0;
      end
      ST_RET_POP: begin
        seq_busy = 1'b1;
        fd_en    = 1'b0;
        if (cnt == RET_LAST) begin
          jump_sel = JS_MEM;
          cnt_nx   = '0;
          if (irq_pend) begin
            state_nx    = ST_INT_PUSH;
            irq_pend_nx = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          pc_en  = 1'b0;
          uop    = uop_bundle(MEM_POP);
          cnt_nx = cnt + 3'd1;
        end
      end
      ST_INT_PUSH: begin
        seq_busy = 1'b1;
        fd_en    = 1'b0;
        if (cnt == INT_LAST) begin
          jump_sel = JS_VEC;
          cnt_nx   = '0;
          if (irq_pend) begin
            state_nx    = ST_INT_PUSH;
            irq_pend_nx = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          pc_en  = 1'b0;
          uop    = (cnt == 3'd0) ? uop_bundle(MEM_PUSHF) : uop_bundle(MEM_PUSHPC);
          cnt_nx = cnt + 3'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Sequencer micro-ops are never squashed; normal slots are zeroed on flush/hazard.
  always_comb begin
    if (seq_busy)    bundle = uop;
    else if (squash) bundle = '0;
    else             bundle = rom_bundle;
  end

  assign ex_ctl  = bundle.ex;
  assign mem_ctl = bundle.mem;
  assign wb_ctl  = bundle.wb;
  assign pop_ok  = !(state == ST_RET_POP || state == ST_RTI_POP);

  assign dbg.state    = state;
  assign dbg.cnt      = cnt;
  assign dbg.irq_pend = irq_pend;

endmodule
